// File: rtl/filter_dispatcher_delay_pipe_pkg.sv
// Shared width constants, cell-ID type and home-cell helper for the filter
// dispatcher staging pipe.
package MD_pkg;

  localparam int NUM_AXES             = 3;
  localparam int DATA_WIDTH           = 16;
  localparam int CELL_ID_WIDTH        = 2;
  localparam int OFFSET_WIDTH         = DATA_WIDTH - CELL_ID_WIDTH;
  localparam int POS_STRUCT_WIDTH     = NUM_AXES * DATA_WIDTH;
  localparam int OFFSET_STRUCT_WIDTH  = NUM_AXES * OFFSET_WIDTH;
  localparam int PARTICLE_ID_WIDTH    = 8;
  localparam int ELEMENT_WIDTH        = 2;
  // Packet layout, MSB first: {particle id, element, position / offset}
  localparam int POS_PKT_STRUCT_WIDTH    = PARTICLE_ID_WIDTH + ELEMENT_WIDTH + POS_STRUCT_WIDTH;
  localparam int OFFSET_PKT_STRUCT_WIDTH = PARTICLE_ID_WIDTH + ELEMENT_WIDTH + OFFSET_STRUCT_WIDTH;
  localparam int NUM_FILTER_SOURCES   = 2;
  localparam int NUM_FILTERS          = 7;

  typedef logic [CELL_ID_WIDTH-1:0] cell_id_t;

  localparam cell_id_t HOME_CELL_ID_DEFAULT = 2'b10;

  // True when the cell-ID field (top bits of every axis word) matches home_id.
  function automatic logic is_home_cell(input logic [POS_STRUCT_WIDTH-1:0] pos,
                                        input cell_id_t home_id);
    logic match;
    match = 1'b1;
    for (int a = 0; a < NUM_AXES; a++) begin
      if (pos[a*DATA_WIDTH + OFFSET_WIDTH +: CELL_ID_WIDTH] != home_id) match = 1'b0;
    end
    return match;
  endfunction

endpackage

// File: rtl/filter_dispatcher_delay_pipe_md_delay_line.sv
// Enable-gated shift register with synchronous reset. Every tap is exported,
// tap k occupying bits [(k-1)*WIDTH +: WIDTH] of o_taps.
module md_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic [WIDTH-1:0]       i_d,
  output logic [DEPTH*WIDTH-1:0] o_taps
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("md_delay_line: DEPTH must be at least 1");
  end

  logic [DEPTH:1][WIDTH-1:0] r_stage;

  // Shift one stage per enabled cycle; a reset empties the whole line.
  // NOTE: every stage is reset so in-flight data is discarded on a mid-stream
  // reset, and the shift uses <= so each stage samples the old neighbour value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else if (i_en) begin
      r_stage[1] <= i_d;
      for (int k = 2; k <= DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_taps = r_stage;

endmodule

// File: rtl/filter_dispatcher_delay_pipe.sv
// Staging pipe between the filter-dispatcher arbiters and the filter bank.
// Delays arbitration/selection/release signals, replicates neighbour and home
// data per filter source, supports a global stall.
// Optional statistics counters: define FILTER_DISPATCH_STATS_EN.
module filter_dispatcher_delay_pipe
  import MD_pkg::*;
#(
  parameter int       NUM_SRC      = NUM_FILTER_SOURCES,
  parameter int       NUM_FILT     = NUM_FILTERS,
  parameter int       IN_ARB_DLY   = 2,
  parameter int       OUT_ARB_DLY  = 3,
  parameter int       REL_DLY      = 2,
  parameter cell_id_t HOME_CELL_ID = HOME_CELL_ID_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_stall,
`ifdef FILTER_DISPATCH_STATS_EN
  input  logic                                   i_stats_clr,
  output logic [31:0]                            o_pair_cnt,
  output logic [31:0]                            o_release_cnt,
`endif
  input  logic [POS_PKT_STRUCT_WIDTH-1:0]        i_nb_data,
  input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]     i_home_data,
  input  logic                                   i_home_load,
  input  logic [NUM_FILT-1:0]                    i_in_arb,
  input  logic [NUM_FILT-1:0]                    i_out_arb,
  input  logic                                   i_pair_valid,
  input  logic [POS_PKT_STRUCT_WIDTH-1:0]        i_nb_sel,
  input  logic [PARTICLE_ID_WIDTH-1:0]           i_home_sel_parid,
  input  logic                                   i_nb_release,
  output logic [NUM_SRC*POS_PKT_STRUCT_WIDTH-1:0] o_nb_data,
  output logic [NUM_SRC-1:0]                     o_nb_home_flag,
  output logic [NUM_SRC*POS_STRUCT_WIDTH-1:0]    o_home_pos,
  output logic [NUM_SRC*PARTICLE_ID_WIDTH-1:0]   o_home_parid,
  output logic [NUM_SRC*ELEMENT_WIDTH-1:0]       o_home_element,
  output logic [NUM_FILT-1:0]                    o_in_arb_d1,
  output logic [NUM_FILT-1:0]                    o_in_arb_dly,
  output logic [NUM_FILT-1:0]                    o_out_arb_d1,
  output logic [NUM_FILT-1:0]                    o_out_arb_dly,
  output logic                                   o_pair_valid,
  output logic [POS_PKT_STRUCT_WIDTH-1:0]        o_nb_sel,
  output logic [PARTICLE_ID_WIDTH-1:0]           o_home_sel_parid,
  output logic                                   o_nb_release_dly
);

  localparam int SEL_W = 1 + POS_PKT_STRUCT_WIDTH + PARTICLE_ID_WIDTH;

  if (IN_ARB_DLY < 2 || OUT_ARB_DLY < 1 || REL_DLY < 1 || NUM_SRC < 1 || NUM_FILT < 1) begin : g_param_chk
    $error("filter_dispatcher_delay_pipe: illegal depth or width parameter");
  end

  logic                            w_en;
  logic [IN_ARB_DLY*NUM_FILT-1:0]  w_in_arb_taps;
  logic [OUT_ARB_DLY*NUM_FILT-1:0] w_out_arb_taps;
  logic [REL_DLY-1:0]              w_rel_taps;
  logic [SEL_W-1:0]                w_sel_taps;
  logic                            w_unused_taps;
  logic                            w_nb_is_home;
  logic [POS_STRUCT_WIDTH-1:0]     w_home_pos;

  logic [NUM_SRC*POS_PKT_STRUCT_WIDTH-1:0] r_nb_data;
  logic [NUM_SRC-1:0]                      r_nb_home_flag;
  logic [NUM_SRC*POS_STRUCT_WIDTH-1:0]     r_home_pos;
  logic [NUM_SRC*PARTICLE_ID_WIDTH-1:0]    r_home_parid;
  logic [NUM_SRC*ELEMENT_WIDTH-1:0]        r_home_element;

  assign w_en = ~i_stall;

  md_delay_line #(.WIDTH(NUM_FILT), .DEPTH(IN_ARB_DLY)) u_in_arb_dly (
    .clk(clk), .rst(rst), .i_en(w_en), .i_d(i_in_arb), .o_taps(w_in_arb_taps)
  );

  md_delay_line #(.WIDTH(NUM_FILT), .DEPTH(OUT_ARB_DLY)) u_out_arb_dly (
    .clk(clk), .rst(rst), .i_en(w_en), .i_d(i_out_arb), .o_taps(w_out_arb_taps)
  );

  md_delay_line #(.WIDTH(1), .DEPTH(REL_DLY)) u_rel_dly (
    .clk(clk), .rst(rst), .i_en(w_en), .i_d(i_nb_release), .o_taps(w_rel_taps)
  );

  md_delay_line #(.WIDTH(SEL_W), .DEPTH(1)) u_sel_dly (
    .clk(clk), .rst(rst), .i_en(w_en),
    .i_d({i_pair_valid, i_nb_sel, i_home_sel_parid}), .o_taps(w_sel_taps)
  );

  assign o_in_arb_d1      = w_in_arb_taps[NUM_FILT-1:0];
  assign o_in_arb_dly     = w_in_arb_taps[(IN_ARB_DLY-1)*NUM_FILT +: NUM_FILT];
  assign o_out_arb_d1     = w_out_arb_taps[NUM_FILT-1:0];
  assign o_out_arb_dly    = w_out_arb_taps[(OUT_ARB_DLY-1)*NUM_FILT +: NUM_FILT];
  assign o_nb_release_dly = w_rel_taps[REL_DLY-1];
  assign {o_pair_valid, o_nb_sel, o_home_sel_parid} = w_sel_taps;

  // Intermediate taps are only visible for debug; fold them so none dangle.
  assign w_unused_taps = ^{w_in_arb_taps, w_out_arb_taps, w_rel_taps};

  assign w_nb_is_home = is_home_cell(i_nb_data[POS_STRUCT_WIDTH-1:0], HOME_CELL_ID);

  // Rebuild the full home position by prefixing each axis offset with the home cell ID.
  // NOTE: the default assignment ahead of the loop keeps this purely combinational.
  always_comb begin
    w_home_pos = '0;
    for (int a = 0; a < NUM_AXES; a++) begin
      w_home_pos[a*DATA_WIDTH +: DATA_WIDTH] = {HOME_CELL_ID, i_home_data[a*OFFSET_WIDTH +: OFFSET_WIDTH]};
    end
  end

  // Neighbour replicas and home flag follow the input on every unstalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nb_data      <= '0;
      r_nb_home_flag <= '0;
    end else if (!i_stall) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_nb_data[i*POS_PKT_STRUCT_WIDTH +: POS_PKT_STRUCT_WIDTH] <= i_nb_data;
        r_nb_home_flag[i] <= w_nb_is_home;
      end
    end
  end

  // Home copies change only on an explicit, unstalled load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_home_pos     <= '0;
      r_home_parid   <= '0;
      r_home_element <= '0;
    end else if (!i_stall && i_home_load) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_home_pos[i*POS_STRUCT_WIDTH +: POS_STRUCT_WIDTH] <= w_home_pos;
        r_home_parid[i*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH] <=
          i_home_data[OFFSET_STRUCT_WIDTH + ELEMENT_WIDTH +: PARTICLE_ID_WIDTH];
        r_home_element[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <=
          i_home_data[OFFSET_STRUCT_WIDTH +: ELEMENT_WIDTH];
      end
    end
  end

  assign o_nb_data      = r_nb_data;
  assign o_nb_home_flag = r_nb_home_flag;
  assign o_home_pos     = r_home_pos;
  assign o_home_parid   = r_home_parid;
  assign o_home_element = r_home_element;

`ifdef FILTER_DISPATCH_STATS_EN
  logic [31:0] r_pair_cnt;
  logic [31:0] r_release_cnt;

  // Saturating event counters; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst || i_stats_clr) begin
      r_pair_cnt    <= '0;
      r_release_cnt <= '0;
    end else if (!i_stall) begin
      if (o_pair_valid && r_pair_cnt != 32'hFFFF_FFFF)        r_pair_cnt    <= r_pair_cnt + 32'd1;
      if (o_nb_release_dly && r_release_cnt != 32'hFFFF_FFFF) r_release_cnt <= r_release_cnt + 32'd1;
    end
  end

  assign o_pair_cnt    = r_pair_cnt;
  assign o_release_cnt = r_release_cnt;
`endif

endmodule

// File: tb/tb_filter_dispatcher_delay_pipe.sv
// Directed bench for filter_dispatcher_delay_pipe. A second instance with
// HOME_CELL_ID=2'b01 covers the parametrised home-cell match.
module tb_filter_dispatcher_delay_pipe;
  import MD_pkg::*;

  localparam int NS = NUM_FILTER_SOURCES;
  localparam int NF = NUM_FILTERS;
  localparam int PW = POS_PKT_STRUCT_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic i_stall;
  logic [PW-1:0] i_nb_data;
  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_home_data;
  logic i_home_load;
  logic [NF-1:0] i_in_arb, i_out_arb;
  logic i_pair_valid;
  logic [PW-1:0] i_nb_sel;
  logic [PARTICLE_ID_WIDTH-1:0] i_home_sel_parid;
  logic i_nb_release;

  logic [NS*PW-1:0]                o_nb_data, o_nb_data_b;
  logic [NS-1:0]                   o_nb_home_flag, o_nb_home_flag_b;
  logic [NS*POS_STRUCT_WIDTH-1:0]  o_home_pos, o_home_pos_b;
  logic [NS*PARTICLE_ID_WIDTH-1:0] o_home_parid, o_home_parid_b;
  logic [NS*ELEMENT_WIDTH-1:0]     o_home_element, o_home_element_b;
  logic [NF-1:0] o_in_arb_d1, o_in_arb_dly, o_out_arb_d1, o_out_arb_dly;
  logic [NF-1:0] o_in_arb_d1_b, o_in_arb_dly_b, o_out_arb_d1_b, o_out_arb_dly_b;
  logic o_pair_valid, o_pair_valid_b;
  logic [PW-1:0] o_nb_sel, o_nb_sel_b;
  logic [PARTICLE_ID_WIDTH-1:0] o_home_sel_parid, o_home_sel_parid_b;
  logic o_nb_release_dly, o_nb_release_dly_b;
`ifdef FILTER_DISPATCH_STATS_EN
  logic i_stats_clr;
  logic [31:0] o_pair_cnt, o_release_cnt, o_pair_cnt_b, o_release_cnt_b;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  filter_dispatcher_delay_pipe dut (
    .clk(clk), .rst(rst), .i_stall(i_stall),
`ifdef FILTER_DISPATCH_STATS_EN
    .i_stats_clr(i_stats_clr), .o_pair_cnt(o_pair_cnt), .o_release_cnt(o_release_cnt),
`endif
    .i_nb_data(i_nb_data), .i_home_data(i_home_data), .i_home_load(i_home_load),
    .i_in_arb(i_in_arb), .i_out_arb(i_out_arb), .i_pair_valid(i_pair_valid),
    .i_nb_sel(i_nb_sel), .i_home_sel_parid(i_home_sel_parid), .i_nb_release(i_nb_release),
    .o_nb_data(o_nb_data), .o_nb_home_flag(o_nb_home_flag), .o_home_pos(o_home_pos),
    .o_home_parid(o_home_parid), .o_home_element(o_home_element),
    .o_in_arb_d1(o_in_arb_d1), .o_in_arb_dly(o_in_arb_dly),
    .o_out_arb_d1(o_out_arb_d1), .o_out_arb_dly(o_out_arb_dly),
    .o_pair_valid(o_pair_valid), .o_nb_sel(o_nb_sel), .o_home_sel_parid(o_home_sel_parid),
    .o_nb_release_dly(o_nb_release_dly)
  );

  filter_dispatcher_delay_pipe #(.HOME_CELL_ID(2'b01)) dut_b (
    .clk(clk), .rst(rst), .i_stall(i_stall),
`ifdef FILTER_DISPATCH_STATS_EN
    .i_stats_clr(i_stats_clr), .o_pair_cnt(o_pair_cnt_b), .o_release_cnt(o_release_cnt_b),
`endif
    .i_nb_data(i_nb_data), .i_home_data(i_home_data), .i_home_load(i_home_load),
    .i_in_arb(i_in_arb), .i_out_arb(i_out_arb), .i_pair_valid(i_pair_valid),
    .i_nb_sel(i_nb_sel), .i_home_sel_parid(i_home_sel_parid), .i_nb_release(i_nb_release),
    .o_nb_data(o_nb_data_b), .o_nb_home_flag(o_nb_home_flag_b), .o_home_pos(o_home_pos_b),
    .o_home_parid(o_home_parid_b), .o_home_element(o_home_element_b),
    .o_in_arb_d1(o_in_arb_d1_b), .o_in_arb_dly(o_in_arb_dly_b),
    .o_out_arb_d1(o_out_arb_d1_b), .o_out_arb_dly(o_out_arb_dly_b),
    .o_pair_valid(o_pair_valid_b), .o_nb_sel(o_nb_sel_b), .o_home_sel_parid(o_home_sel_parid_b),
    .o_nb_release_dly(o_nb_release_dly_b)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Neighbour packet with the given per-axis cell IDs (axis 2 first).
  function automatic logic [PW-1:0] mk_nb(input cell_id_t c2, input cell_id_t c1, input cell_id_t c0);
    return {8'h5A, 2'b11, c2, 14'h0111, c1, 14'h0222, c0, 14'h0333};
  endfunction

  logic [PW-1:0] nb_v;

  initial begin
    // Reset with every input driven high
    rst = 1'b1; i_stall = 1'b1; i_home_load = 1'b1;
    i_nb_data = '1; i_home_data = '1; i_in_arb = '1; i_out_arb = '1;
    i_pair_valid = 1'b1; i_nb_sel = '1; i_home_sel_parid = '1; i_nb_release = 1'b1;
`ifdef FILTER_DISPATCH_STATS_EN
    i_stats_clr = 1'b1;
`endif
    repeat (3) step();
    check("rst_nb_data",   128'(o_nb_data), 128'd0);
    check("rst_home_flag", 128'(o_nb_home_flag), 128'd0);
    check("rst_home_pos",  128'(o_home_pos), 128'd0);
    check("rst_home_parid", 128'(o_home_parid), 128'd0);
    check("rst_arb", 128'({o_in_arb_d1, o_in_arb_dly, o_out_arb_d1, o_out_arb_dly}), 128'd0);
    check("rst_sel", 128'({o_pair_valid, o_nb_sel, o_home_sel_parid, o_nb_release_dly}), 128'd0);

    // Release reset: replicas follow the input one cycle later
    rst = 1'b0; i_stall = 1'b0;
`ifdef FILTER_DISPATCH_STATS_EN
    i_stats_clr = 1'b0;
`endif
    step();
    check("post_rst_nb_data", 128'(o_nb_data), 128'({NS*PW{1'b1}}));
    check("post_rst_flag", 128'(o_nb_home_flag), 128'd0);

    // Flush to an all-zero input state
    i_home_load = 1'b0; i_nb_data = '0; i_home_data = '0; i_in_arb = '0; i_out_arb = '0;
    i_pair_valid = 1'b0; i_nb_sel = '0; i_home_sel_parid = '0; i_nb_release = 1'b0;
    repeat (4) step();
    check("flush_out_arb_dly", 128'(o_out_arb_dly), 128'd0);

    // Output-arb depth: tap 1 at +1, tap 3 at +3, one cycle each
    i_out_arb = 7'b0000100;
    step(); i_out_arb = '0;
    check("oarb_d1_+1",  128'(o_out_arb_d1), 128'(7'b0000100));
    check("oarb_dly_+1", 128'(o_out_arb_dly), 128'd0);
    step();
    check("oarb_d1_+2",  128'(o_out_arb_d1), 128'd0);
    check("oarb_dly_+2", 128'(o_out_arb_dly), 128'd0);
    step();
    check("oarb_dly_+3", 128'(o_out_arb_dly), 128'(7'b0000100));
    step();
    check("oarb_dly_+4", 128'(o_out_arb_dly), 128'd0);

    // Stall: tap 1 holds, tap 2 appears one cycle after the stall drops
    i_in_arb = 7'b0010000;
    step(); i_in_arb = '0;
    check("iarb_d1_pre", 128'(o_in_arb_d1), 128'(7'b0010000));
    i_stall = 1'b1;
    i_nb_data = mk_nb(2'b10, 2'b10, 2'b10);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("stall_iarb_d1_%0d", c), 128'(o_in_arb_d1), 128'(7'b0010000));
      check($sformatf("stall_iarb_dly_%0d", c), 128'(o_in_arb_dly), 128'd0);
    end
    check("stall_nb_hold", 128'(o_nb_data), 128'd0);
    i_stall = 1'b0; i_nb_data = '0;
    step();
    check("unstall_iarb_dly", 128'(o_in_arb_dly), 128'(7'b0010000));
    check("unstall_iarb_d1",  128'(o_in_arb_d1), 128'd0);
    step();
    check("unstall_iarb_dly2", 128'(o_in_arb_dly), 128'd0);

    // Home flag for both HOME_CELL_ID settings
    nb_v = mk_nb(2'b10, 2'b10, 2'b10); i_nb_data = nb_v;
    step();
    check("flag_101010",   128'(o_nb_home_flag),   128'(2'b11));
    check("flag_101010_b", 128'(o_nb_home_flag_b), 128'(2'b00));
    check("nb_repl",       128'(o_nb_data), 128'({nb_v, nb_v}));
    i_nb_data = mk_nb(2'b10, 2'b11, 2'b10);
    step();
    check("flag_101110", 128'(o_nb_home_flag), 128'(2'b00));
    i_nb_data = mk_nb(2'b01, 2'b01, 2'b01);
    step();
    check("flag_010101",   128'(o_nb_home_flag),   128'(2'b00));
    check("flag_010101_b", 128'(o_nb_home_flag_b), 128'(2'b11));

    // Home load strobe
    i_home_data = {8'h11, 2'b10, 14'h0AAA, 14'h0BBB, 14'h0CCC}; i_home_load = 1'b1;
    step(); i_home_load = 1'b0;
    check("home_parid_11", 128'(o_home_parid), 128'({8'h11, 8'h11}));
    i_home_data = {8'h2A, 2'b01, 14'h0789, 14'h0456, 14'h0123};
    repeat (2) step();
    check("home_noload_parid", 128'(o_home_parid),   128'({8'h11, 8'h11}));
    check("home_noload_elem",  128'(o_home_element), 128'({2'b10, 2'b10}));
    i_home_load = 1'b1;
    step(); i_home_load = 1'b0;
    check("home_parid_2a", 128'(o_home_parid), 128'({8'h2A, 8'h2A}));
    check("home_elem",     128'(o_home_element), 128'({2'b01, 2'b01}));
    check("home_pos", 128'(o_home_pos),
          128'({2{2'b10, 14'h0789, 2'b10, 14'h0456, 2'b10, 14'h0123}}));
    check("home_pos_b", 128'(o_home_pos_b),
          128'({2{2'b01, 14'h0789, 2'b01, 14'h0456, 2'b01, 14'h0123}}));
    i_home_data = {8'h11, 2'b10, 14'h0AAA, 14'h0BBB, 14'h0CCC};
    i_home_load = 1'b1; i_stall = 1'b1;
    step(); i_home_load = 1'b0; i_stall = 1'b0;
    check("home_load_stalled", 128'(o_home_parid), 128'({8'h2A, 8'h2A}));

    // Pair/selection delayed 1, release delayed 2
    nb_v = mk_nb(2'b00, 2'b11, 2'b01);
    i_pair_valid = 1'b1; i_nb_sel = nb_v; i_home_sel_parid = 8'h77; i_nb_release = 1'b1;
    step();
    i_pair_valid = 1'b0; i_nb_sel = '0; i_home_sel_parid = '0; i_nb_release = 1'b0;
    check("sel_+1", 128'({o_pair_valid, o_nb_sel, o_home_sel_parid}), 128'({1'b1, nb_v, 8'h77}));
    check("rel_+1", 128'(o_nb_release_dly), 128'd0);
    step();
    check("sel_+2", 128'(o_pair_valid), 128'd0);
    check("rel_+2", 128'(o_nb_release_dly), 128'd1);
    step();
    check("rel_+3", 128'(o_nb_release_dly), 128'd0);

    // Mid-stream reset discards in-flight data
    i_in_arb = 7'b1000000;
    step(); i_in_arb = '0; rst = 1'b1;
    step(); rst = 1'b0;
    check("midrst_iarb", 128'({o_in_arb_d1, o_in_arb_dly}), 128'd0);
    i_in_arb = 7'b0000001;
    step(); i_in_arb = '0;
    check("midrst_d1",  128'(o_in_arb_d1), 128'(7'b0000001));
    check("midrst_dly", 128'(o_in_arb_dly), 128'd0);
    step();
    check("midrst_dly2", 128'(o_in_arb_dly), 128'(7'b0000001));
    check("midrst_home", 128'(o_home_parid), 128'd0);

`ifdef FILTER_DISPATCH_STATS_EN
    // 5 valid pairs presented, 2 of them during stall -> 3 counted
    i_stats_clr = 1'b1;
    step(); i_stats_clr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_pair_valid = 1'b1; i_stall = (c == 1 || c == 3);
      step();
    end
    i_pair_valid = 1'b0; i_stall = 1'b0;
    repeat (2) step();
    check("stats_pair_cnt", 128'(o_pair_cnt), 128'd3);
    i_pair_valid = 1'b1;
    step(); i_pair_valid = 1'b0; i_stats_clr = 1'b1;
    step(); i_stats_clr = 1'b0;
    check("stats_clr_beats_inc", 128'(o_pair_cnt), 128'd0);
    check("stats_rel_cnt", 128'(o_release_cnt), 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
